vga_sync_generator: RTL
=======================

# vga_sync_generator

Raster timing generator for the 640x480@60 Hz VGA output, clocked directly by the 25 MHz pixel clock from the PLL clock generator stage. Walks a horizontal/vertical pixel counter pair and produces registered hsync/vsync, a display-active flag, the current pixel coordinates and line/frame start strobes. The sprite and bullet renderers downstream consume these signals.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk_25MHz  input  1  pixel clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- display_active  output  1  high while (x, y) is inside the visible area
- x  output  10  current pixel column, 0..H_TOTAL-1
- y  output  10  current line, 0..V_TOTAL-1
- line_start  output  1  one-cycle strobe, high when x == 0
- frame_start  output  1  one-cycle strobe, high when x == 0 and y == 0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both totals must be ≤ 1024; all arithmetic is unsigned 10-bit.
- Two states: IDLE and RUN. Reset forces IDLE. IDLE -> RUN on the first rising edge with reset low. RUN -> IDLE only via reset.
- IDLE outputs: x=0, y=0, hsync=1, vsync=1, display_active=0, line_start=0, frame_start=0.
- On the IDLE->RUN edge, the outputs load the decode of pixel (0,0). Each following RUN edge advances one pixel.
- Advance: if x == H_TOTAL-1, then x wraps to 0 and y increments. If y was also V_TOTAL-1, y wraps to 0. Otherwise x increments.
- All outputs are registered and refer to the same (x, y) in the same cycle. No output is a combinational decode of another output. The implementation computes the next position and registers it together with its decodes.
- hsync = 0 iff H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC (656..751).
- vsync = 0 iff V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC (490..491), for the whole of each such line, including its porch/sync pixels.
- display_active = (x < H_ACTIVE) and (y < V_ACTIVE).
- line_start = (x == 0) in RUN; frame_start = (x == 0 and y == 0) in RUN.

## Timing
- Reset dominates: if reset is sampled high in any cycle, all outputs take IDLE values on that edge, including mid-line and mid-frame.
- There is no partial-frame continuation after reset. The first RUN pixel is always (0,0), with frame_start=1 and display_active=1.
- Latency from reset deassertion (first low sample) to the first valid pixel (0,0) on the outputs: 1 clock.
- Line period: exactly H_TOTAL clocks. Frame period: exactly H_TOTAL*V_TOTAL clocks (420000). No stalls, no enable input.
- hsync low pulse: 96 consecutive clocks per line, falling at x=656 and rising at x=752. The pattern is identical on every line, including blanking lines.
- vsync low pulse: 2*H_TOTAL = 1600 clocks. It falls at (0,490) and rises at (0,492).
- Wrap at (799,524) -> (0,0): y wraps on the same edge as x, and frame_start asserts on that edge.

## Test plan
- Reset values: hold reset high for 5 cycles, then check x=0, y=0, hsync=1, vsync=1, display_active=0, line_start=0, frame_start=0. This includes the edge where reset first rises mid-frame.
- First pixel: deassert reset, then after 1 clock check x=0, y=0, display_active=1, line_start=1, frame_start=1. After the next clock check x=1 and both strobes 0.
- Horizontal timing over one line: display_active is high for x=0..639 (640 clocks). hsync is low for exactly x=656..751. line_start pulses once every 800 clocks.
- Vertical timing: display_active is 0 for all y ≥ 480. vsync is low only on lines 490 and 491 (1600 clocks). Over one frame, count exactly 525 line_start pulses.
- Frame wrap: after 420000 clocks from the first pixel, the outputs are again x=0, y=0 with frame_start=1. Consecutive frame_start pulses are exactly 420000 clocks apart, across 3 frames.
- Reset mid-operation: assert reset for 1 cycle at (700,300). The outputs go to IDLE values, the next cycle presents (0,0) with frame_start=1, and the following frame_start occurs 420000 clocks later.

Source files
------------

// File: rtl/vga_sync_generator.sv
// vga_sync_generator
// Raster timing for a 640x480@60 Hz VGA output, clocked by the 25 MHz pixel
// clock. A horizontal/vertical counter pair walks the raster. hsync/vsync,
// display_active, the pixel coordinates and the line/frame strobes all come
// from flops, so every output describes the same pixel in the same cycle.
// The next position is computed combinationally and decoded before it is
// registered. No output is derived from another registered output.
// Both totals (active + porches + sync) must not exceed 1024, because the
// counters are 10 bits wide.

module vga_sync_generator #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk_25MHz,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       display_active,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  // Raster geometry.
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last column and last line, used as the counter wrap points.
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Decode bounds are 11 bits wide. A bound equal to 1024 (for example,
  // sync ending exactly at the line end) then still compares correctly.
  localparam logic [10:0] H_ACT_END    = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END    = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  // IDLE holds the blanked, deasserted outputs until the first edge
  // without reset. RUN then scans the raster indefinitely.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  // Registered position. These registers drive x and y directly.
  logic [9:0] r_x;
  logic [9:0] r_y;

  // Registered decodes of the position held in r_x/r_y.
  logic       r_hsync;
  logic       r_vsync;
  logic       r_display_active;
  logic       r_line_start;
  logic       r_frame_start;

  // Position that will be presented after the coming edge.
  logic [9:0] w_x_next;
  logic [9:0] w_y_next;
  logic       w_x_at_end;
  logic       w_y_at_end;

  // Decodes of the next position, registered alongside it.
  logic [10:0] w_x_next_ext;
  logic [10:0] w_y_next_ext;
  logic        w_run_next;
  logic        w_hsync_next;
  logic        w_vsync_next;
  logic        w_display_active_next;
  logic        w_line_start_next;
  logic        w_frame_start_next;

  assign w_x_at_end = (r_x == H_LAST);
  assign w_y_at_end = (r_y == V_LAST);

  // Next-state and next-position logic of the scan FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves
    // a value unassigned and no latch can be inferred.
    w_state_next = r_state;
    w_x_next     = '0;
    w_y_next     = '0;

    case (r_state)
      ST_IDLE: begin
        // Leaving IDLE always starts a fresh frame at (0,0).
        w_state_next = ST_RUN;
      end

      ST_RUN: begin
        if (w_x_at_end) begin
          w_x_next = '0;
          w_y_next = w_y_at_end ? 10'd0 : (r_y + 10'd1);
        end else begin
          w_x_next = r_x + 10'd1;
          w_y_next = r_y;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Decode the next position into sync, blanking and strobe values.
  always_comb begin
    w_x_next_ext          = {1'b0, w_x_next};
    w_y_next_ext          = {1'b0, w_y_next};
    w_run_next            = (w_state_next == ST_RUN);

    // The sync outputs are active low. They stay high outside RUN.
    w_hsync_next          = ~(w_run_next &&
                              (w_x_next_ext >= H_SYNC_START) &&
                              (w_x_next_ext <  H_SYNC_END));
    // vsync covers whole lines, including their porch and sync pixels.
    w_vsync_next          = ~(w_run_next &&
                              (w_y_next_ext >= V_SYNC_START) &&
                              (w_y_next_ext <  V_SYNC_END));
    w_display_active_next = w_run_next &&
                            (w_x_next_ext < H_ACT_END) &&
                            (w_y_next_ext < V_ACT_END);
    w_line_start_next     = w_run_next && (w_x_next == 10'd0);
    w_frame_start_next    = w_run_next && (w_x_next == 10'd0) &&
                            (w_y_next == 10'd0);
  end

  // State, position and decoded outputs, with synchronous reset to IDLE.
  always_ff @(posedge clk_25MHz) begin
    // NOTE: non-blocking assignments here. Every register samples the
    // pre-edge values, so the position and its decodes stay aligned.
    if (reset) begin
      r_state          <= ST_IDLE;
      r_x              <= '0;
      r_y              <= '0;
      r_hsync          <= 1'b1;
      r_vsync          <= 1'b1;
      r_display_active <= 1'b0;
      r_line_start     <= 1'b0;
      r_frame_start    <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_x              <= w_x_next;
      r_y              <= w_y_next;
      r_hsync          <= w_hsync_next;
      r_vsync          <= w_vsync_next;
      r_display_active <= w_display_active_next;
      r_line_start     <= w_line_start_next;
      r_frame_start    <= w_frame_start_next;
    end
  end

  assign hsync          = r_hsync;
  assign vsync          = r_vsync;
  assign display_active = r_display_active;
  assign x              = r_x;
  assign y              = r_y;
  assign line_start     = r_line_start;
  assign frame_start    = r_frame_start;

endmodule
